// File: rtl/tt_sweep_checker.sv
// Exhaustive 4-input sweep driver and response checker: drives all 16 patterns on a..d,
// samples f at the end of each dwell, and compares the captured truth table with EXPECTED.
module tt_sweep_checker #(
    parameter int unsigned DWELL    = 20,
    parameter logic [15:0] EXPECTED = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_count
);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StDone
    } state_e;

    localparam logic [7:0] CntLast = 8'(DWELL - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] tt_q, tt_d;
    logic [4:0]  mm_q, mm_d;
    logic [3:0]  pat_q, pat_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            tt_q    <= 16'd0;
            mm_q    <= 5'd0;
            pat_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            pat_q   <= pat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        mm_d    = mm_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StDrive;
                    idx_d   = 4'd0;
                    cnt_d   = 8'd0;
                    tt_d    = 16'd0;
                    mm_d    = 5'd0;
                end
            end
            StDrive: begin
                if (cnt_q == CntLast) begin
                    tt_d[idx_q] = f;
                    if (f != EXPECTED[idx_q]) begin
                        mm_d = mm_q + 5'd1;
                    end
                    if (idx_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        cnt_d = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Stimulus is registered from the next-state view so a..d change cleanly on the edge.
        pat_d = (state_d == StDrive) ? idx_d : 4'd0;
    end

    assign {a, b, c, d}   = pat_q;
    assign busy           = (state_q == StDrive);
    assign done           = (state_q == StDone);
    assign pass           = done && (tt_q == EXPECTED);
    assign truth_table    = tt_q;
    assign mismatch_count = mm_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: random and directed DUT functions, checked against
// a truth-table model computed directly from the function being swept.
module tb_tt_sweep_checker;

    localparam int unsigned DW = 3;
    localparam logic [15:0] EXP = 16'h6996;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic a, b, c, d, f, busy, done, pass;
    logic [15:0] truth_table;
    logic [4:0]  mismatch_count;
    logic [15:0] fn = 16'h0000;

    // Second instance exercises the single-cycle dwell with a fixed XOR4 DUT.
    logic start1 = 1'b0;
    logic a1, b1, c1, d1, f1, busy1, done1, pass1;
    logic [15:0] tt1;
    logic [4:0]  mm1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          t0;
        logic [15:0] tt;
        logic [4:0]  mm;
        logic        pass;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign f  = fn[{a, b, c, d}];
    assign f1 = a1 ^ b1 ^ c1 ^ d1;

    tt_sweep_checker #(.DWELL(DW), .EXPECTED(EXP)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .d(d), .f(f),
        .busy(busy), .done(done), .pass(pass), .truth_table(truth_table),
        .mismatch_count(mismatch_count)
    );

    tt_sweep_checker #(.DWELL(1), .EXPECTED(16'h6996)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .d(d1), .f(f1),
        .busy(busy1), .done(done1), .pass(pass1), .truth_table(tt1),
        .mismatch_count(mm1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int t0, input logic [15:0] fv);
        exp_t e;
        e.t0   = t0;
        e.tt   = fv;
        e.mm   = 5'($countones(fv ^ EXP));
        e.pass = (fv == EXP);
        return e;
    endfunction

    // Issue start for one cycle with a given DUT function and queue the expected result.
    task automatic launch(input logic [15:0] fv, input bit hold);
        @(negedge clk);
        fn    = fv;
        start = 1'b1;
        @(posedge clk);
        #1;
        sbq.push_back(model(cyc, fv));
        if (hold) sbq.push_back(model(cyc + 16 * DW + 1, fv));
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 * DW * 16 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            chk("sweep_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    // Monitor: per-cycle pattern tracking and result comparison whenever done rises.
    initial begin
        int   seq_bad;
        logic done_prev;
        int   dlt;
        exp_t e;
        seq_bad   = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seq_bad   = 0;
                done_prev = 1'b0;
            end else begin
                if (sbq.size() > 0) begin
                    dlt = cyc - sbq[0].t0;
                    if (dlt >= 0 && dlt < 16 * int'(DW)) begin
                        if (int'({a, b, c, d}) != dlt / int'(DW) || !busy || done || pass)
                            seq_bad++;
                    end
                end
                if (done && !done_prev) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("done_time", 32'(cyc), 32'(e.t0 + 16 * int'(DW)));
                        chk("truth_table", 32'(truth_table), 32'(e.tt));
                        chk("mismatch_count", 32'(mismatch_count), 32'(e.mm));
                        chk("pass", 32'(pass), 32'(e.pass));
                        chk("pattern_seq_bad_cycles", 32'(seq_bad), 32'd0);
                        chk("abcd_busy_in_done", 32'({a, b, c, d, busy}), 32'd0);
                    end
                    seq_bad = 0;
                end
                done_prev = done;
            end
        end
    end

    initial begin
        int bad;
        // Reset state
        #12;
        chk("reset_outputs", 32'({a, b, c, d, busy, done, pass}), 32'd0);
        chk("reset_tables", 32'({truth_table, mismatch_count}), 32'd0);
        chk("reset_outputs_dw1", 32'({a1, b1, c1, d1, busy1, done1, pass1, tt1, mm1}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // DWELL = 1: one pattern per cycle, done at t0+16
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (int'({a1, b1, c1, d1}) != k || !busy1 || done1) bad++;
            @(negedge clk);
        end
        chk("dw1_step_seq_bad", 32'(bad), 32'd0);
        chk("dw1_done_busy", 32'({done1, busy1}), 32'b10);
        chk("dw1_truth_table", 32'(tt1), 32'h6996);
        chk("dw1_pass_mm", 32'({pass1, mm1}), 32'h20);
        @(negedge clk);
        chk("dw1_done_held", 32'({done1, a1, b1, c1, d1}), 32'h10);

        // Directed functions: XOR4 (match), AND4, all-zero, full inversion (16 mismatches)
        launch(16'h6996, 1'b0); wait_idle();
        launch(16'h8000, 1'b0); wait_idle();
        launch(16'h0000, 1'b0); wait_idle();
        launch(16'h9669, 1'b0); wait_idle();
        repeat (2) @(negedge clk);
        chk("done_holds", 32'({done, busy, a, b, c, d}), 32'h20);

        // Random functions, with an occasional exact match
        for (int i = 0; i < 8; i++) begin
            launch((i == 3) ? EXP : 16'($urandom), 1'b0);
            wait_idle();
        end

        // start pulsed mid-sweep at idx 5 must not restart
        launch(16'($urandom), 1'b0);
        repeat (5 * DW) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Asynchronous reset mid-sweep at idx 9, then a clean full sweep
        launch(16'($urandom), 1'b0);
        repeat (9 * DW + 1) @(negedge clk);
        chk("idx9_reached", 32'({a, b, c, d}), 32'd9);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({a, b, c, d, busy, done, pass}), 32'd0);
        chk("async_reset_tables", 32'({truth_table, mismatch_count}), 32'd0);
        sbq.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        launch(16'hC3A5, 1'b0); wait_idle();

        // start held through DONE: one-cycle done pulse, identical second sweep
        launch(16'h1E2D, 1'b1);
        bad = 1;
        for (int i = 0; i < 40 * DW * 16; i++) begin
            @(negedge clk);
            if (done) begin
                bad = 0;
                break;
            end
        end
        chk("held_first_done_seen", 32'(bad), 32'd0);
        @(negedge clk);
        chk("held_done_one_cycle", 32'({done, busy, a, b, c, d}), 32'h10);
        start = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
